// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family.
// Covers direction encoding, a ceil-log2 helper and digit saturation.
package counter_pkg;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Clamp a loaded digit into the legal 0..modulus-1 range.
    function automatic int sat_digit(input int value, input int modulus);
        return (value > modulus - 1) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-MODULUS digit with clear/load/step and a terminal-count flag.
// The flag feeds the carry/borrow chain of the next digit.
module bcd_digit
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          mode,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_d,
    output logic [DW-1:0] q,
    output logic          term
);

    localparam logic [DW-1:0] MAX = DW'(MODULUS - 1);

    logic [DW-1:0] q_d, q_q;

    always_comb begin
        term = (mode == MODE_UP) ? (q_q == MAX) : (q_q == '0);
        q_d  = q_q;
        if (clear)
            q_d = '0;
        else if (load)
            q_d = DW'(sat_digit(int'(load_d), MODULUS));
        else if (step) begin
            if (mode == MODE_UP)
                q_d = term ? '0 : q_q + DW'(1);
            else
                q_d = term ? MAX : q_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-N up/down counter with a registered output stage and
// a whole-counter wrap pulse for cascading.
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10,
    parameter int DW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 clear,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] number,
    output logic                 zero,
    output logic                 wrap
);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "bcd_updown_counter: DIGITS out of range");
    end
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
        $fatal(1, "bcd_updown_counter: MODULUS out of range");
    end
    if (clog2(MODULUS) > DW) begin : g_bad_dw
        $fatal(1, "bcd_updown_counter: DW too narrow for MODULUS");
    end

    logic [DIGITS-1:0][DW-1:0] state;
    logic [DIGITS-1:0]         term, step;
    logic                      wrap_int_d, wrap_int_q;
    logic [DIGITS*DW-1:0]      number_d, number_q;
    logic                      zero_d, zero_q, wrap_q;

    // A digit steps only when every lower digit sits at its terminal value.
    always_comb begin
        logic acc;
        acc = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            step[k] = en & acc;
            acc     = acc & term[k];
        end
        wrap_int_d = en & acc & ~clear & ~load;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit #(.MODULUS(MODULUS), .DW(DW)) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (step[k]),
            .mode   (mode),
            .clear  (clear),
            .load   (load),
            .load_d (load_val[k*DW +: DW]),
            .q      (state[k]),
            .term   (term[k])
        );
    end

    always_comb begin
        number_d = state;
        zero_d   = (state == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_int_q <= 1'b0;
            number_q   <= '0;
            zero_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_int_q <= wrap_int_d;
            number_q   <= number_d;
            zero_q     <= zero_d;
            wrap_q     <= wrap_int_q;
        end
    end

    assign number = number_q;
    assign zero   = zero_q;
    assign wrap   = wrap_q;

endmodule
